seq_detect_p: RTL and testbench

SEQ_DETECT_P -- requirements
Module: seq_detect_p

---
 rtl/seq_detect_p.sv | 167 ++++++++++++++++
 tb/tb_seq_detect_p.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_p.sv
//------------------------------------------------------------------------------
// Module      : seq_detect_p
// Description : Programmable serial pattern detector. A LOAD pulse latches a
//               pattern of 2..PAT_W bits. Serial bits qualified by EN are
//               then shifted into a history register. A one-cycle registered
//               pulse is raised on each match, in overlapping or
//               non-overlapping mode, and a saturating counter counts the
//               matches.
// Ports       : CLK       - clock, rising edge
//               RST       - asynchronous active-low reset
//               In1       - serial data bit
//               EN        - sample-valid qualifier for In1
//               LOAD      - latch PATTERN/PAT_LEN and restart detection
//               PATTERN   - target pattern, bit PAT_LEN-1 is expected first
//               PAT_LEN   - active pattern length
//               OVERLAP   - 1 = overlapping matches, 0 = non-overlapping
//               CLR_CNT   - synchronous clear of MATCH_CNT
//               Out1      - registered one-cycle match pulse
//               MATCH_CNT - saturating match count
//               CNT_SAT   - MATCH_CNT is all-ones
//               CFG_ERR   - last LOAD carried an illegal PAT_LEN
//               ARMED     - detector is in RUN
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_detect_p #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W) + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             In1,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [PAT_W-1:0] PATTERN,
   input  logic [LEN_W-1:0] PAT_LEN,
   input  logic             OVERLAP,
   input  logic             CLR_CNT,
   output logic             Out1,
   output logic [CNT_W-1:0] MATCH_CNT,
   output logic             CNT_SAT,
   output logic             CFG_ERR,
   output logic             ARMED
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [LEN_W-1:0] c_LEN_MIN = LEN_W'(2);
   localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(PAT_W);
   localparam logic [PAT_W-1:0] c_ONE     = {{(PAT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   state_t             r_state;
   logic [PAT_W-1:0]   r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic [PAT_W-1:0]   r_pat;
   logic [LEN_W-1:0]   r_len;
   logic               r_out;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_cfg_err;

   state_t             w_state_nxt;
   logic [PAT_W-1:0]   w_hist_nxt;
   logic [LEN_W-1:0]   w_fill_nxt;
   logic [PAT_W-1:0]   w_pat_nxt;
   logic [LEN_W-1:0]   w_len_nxt;
   logic               w_out_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_cfg_err_nxt;

   logic               w_len_ok;
   logic [PAT_W-1:0]   w_hist_upd;
   logic [LEN_W-1:0]   w_fill_upd;
   logic [PAT_W-1:0]   w_mask;
   logic               w_match;

   // State and datapath registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= ST_IDLE;
         r_hist    <= '0;
         r_fill    <= '0;
         r_pat     <= '0;
         r_len     <= '0;
         r_out     <= 1'b0;
         r_cnt     <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_hist    <= w_hist_nxt;
         r_fill    <= w_fill_nxt;
         r_pat     <= w_pat_nxt;
         r_len     <= w_len_nxt;
         r_out     <= w_out_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cfg_err <= w_cfg_err_nxt;
      end
   end

   // Next-state, datapath and match logic
   always_comb begin
      w_state_nxt   = r_state;
      w_hist_nxt    = r_hist;
      w_fill_nxt    = r_fill;
      w_pat_nxt     = r_pat;
      w_len_nxt     = r_len;
      w_out_nxt     = 1'b0;
      w_cnt_nxt     = r_cnt;
      w_cfg_err_nxt = r_cfg_err;

      w_len_ok   = (PAT_LEN >= c_LEN_MIN) && (PAT_LEN <= c_LEN_MAX);
      w_hist_upd = {r_hist[PAT_W-2:0], In1};
      w_fill_upd = (r_fill == c_LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
      // Low r_len bits set. For r_len == PAT_W the shift wraps to zero and
      // the subtraction yields all-ones, which is the wanted full mask.
      w_mask     = (c_ONE << r_len) - c_ONE;
      w_match    = (r_state == ST_RUN) && EN && !LOAD &&
                   (w_fill_upd >= r_len) &&
                   (((w_hist_upd ^ r_pat) & w_mask) == '0);

      if (LOAD) begin
         // LOAD has priority; the In1 bit of this cycle is dropped
         if (w_len_ok) begin
            w_pat_nxt     = PATTERN;
            w_len_nxt     = PAT_LEN;
            w_hist_nxt    = '0;
            w_fill_nxt    = '0;
            w_cfg_err_nxt = 1'b0;
            w_state_nxt   = ST_RUN;
         end else begin
            w_cfg_err_nxt = 1'b1;
            w_state_nxt   = ST_IDLE;
         end
      end else if ((r_state == ST_RUN) && EN) begin
         w_hist_nxt = w_hist_upd;
         w_fill_nxt = w_fill_upd;
         if (w_match) begin
            w_out_nxt = 1'b1;
            // Non-overlapping: the next match needs a full fresh pattern
            if (!OVERLAP) begin
               w_fill_nxt = '0;
            end
         end
      end

      // Clear wins over a simultaneous match increment
      if (CLR_CNT) begin
         w_cnt_nxt = '0;
      end else if (w_match && (r_cnt != c_CNT_MAX)) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   assign Out1      = r_out;
   assign MATCH_CNT = r_cnt;
   assign CNT_SAT   = (r_cnt == c_CNT_MAX);
   assign CFG_ERR   = r_cfg_err;
   assign ARMED     = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_p.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_detect_p
// Description : Scoreboard bench for seq_detect_p (PAT_W=4, CNT_W=8). The
//               driver pushes the hand-computed response for each clock edge
//               it drives; a monitor pops and compares after every edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_detect_p;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       In1 = 1'b0;
   logic       EN = 1'b0;
   logic       LOAD = 1'b0;
   logic [3:0] PATTERN = 4'd0;
   logic [2:0] PAT_LEN = 3'd0;
   logic       OVERLAP = 1'b0;
   logic       CLR_CNT = 1'b0;
   logic       Out1;
   logic [7:0] MATCH_CNT;
   logic       CNT_SAT;
   logic       CFG_ERR;
   logic       ARMED;

   seq_detect_p #(.PAT_W(4), .CNT_W(8), .LEN_W(3)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .In1       (In1),
      .EN        (EN),
      .LOAD      (LOAD),
      .PATTERN   (PATTERN),
      .PAT_LEN   (PAT_LEN),
      .OVERLAP   (OVERLAP),
      .CLR_CNT   (CLR_CNT),
      .Out1      (Out1),
      .MATCH_CNT (MATCH_CNT),
      .CNT_SAT   (CNT_SAT),
      .CFG_ERR   (CFG_ERR),
      .ARMED     (ARMED)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       out;
      logic [7:0] cnt;
      logic       sat;
      logic       err;
      logic       armed;
   } exp_t;

   exp_t       q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_cnt = 8'd0;
   logic       exp_err = 1'b0;
   logic       exp_armed = 1'b0;
   logic [3:0] nx_pattern = 4'd0;
   logic [2:0] nx_len = 3'd0;
   logic       nx_ovl = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Drive one edge worth of inputs and queue the response expected after it
   task automatic step(input logic in_b, input logic en_b, input logic ld_b,
                       input logic clr_b, input logic eo);
      exp_t e;
      @(negedge CLK);
      In1     = in_b;
      EN      = en_b;
      LOAD    = ld_b;
      CLR_CNT = clr_b;
      PATTERN = nx_pattern;
      PAT_LEN = nx_len;
      OVERLAP = nx_ovl;
      if (clr_b) exp_cnt = 8'd0;
      else if (eo && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      e.out   = eo;
      e.cnt   = exp_cnt;
      e.sat   = (exp_cnt == 8'hFF);
      e.err   = exp_err;
      e.armed = exp_armed;
      q.push_back(e);
   endtask

   // LOAD with In1=1 and EN=1 so a wrongly sampled bit would be visible
   task automatic do_load(input logic [3:0] pat, input logic [2:0] len,
                          input logic ovl, input logic legal);
      nx_pattern = pat;
      nx_len     = len;
      nx_ovl     = ovl;
      exp_armed  = legal;
      exp_err    = !legal;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // bits/exps: first bit in position n-1
   task automatic feed(input int n, input logic [31:0] bits, input logic [31:0] exps);
      for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0, exps[i]);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_Out1"},      32'(Out1),      32'd0);
      chk({tag, "_MATCH_CNT"}, 32'(MATCH_CNT), 32'd0);
      chk({tag, "_CNT_SAT"},   32'(CNT_SAT),   32'd0);
      chk({tag, "_CFG_ERR"},   32'(CFG_ERR),   32'd0);
      chk({tag, "_ARMED"},     32'(ARMED),     32'd0);
   endtask

   // Monitor: compare DUT outputs against the scoreboard after every edge
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("Out1",      32'(Out1),      32'(e.out));
            chk("MATCH_CNT", 32'(MATCH_CNT), 32'(e.cnt));
            chk("CNT_SAT",   32'(CNT_SAT),   32'(e.sat));
            chk("CFG_ERR",   32'(CFG_ERR),   32'(e.err));
            chk("ARMED",     32'(ARMED),     32'(e.armed));
         end
      end
   end

   initial begin
      int t;
      #1 RST = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge CLK);
      RST = 1'b1;

      // IDLE ignores the stream
      feed(4, 32'b1111, 32'b0000);

      // 1011 overlapping: matches after bits 4 and 7
      do_load(4'b1011, 3'd4, 1'b1, 1'b1);
      feed(7, 32'b1011011, 32'b0001001);

      // Same stream non-overlapping: one match; LOAD keeps the count
      do_load(4'b1011, 3'd4, 1'b0, 1'b1);
      feed(7, 32'b1011011, 32'b0001000);

      // EN gap of 3 cycles between bits 2 and 3
      do_load(4'b1011, 3'd4, 1'b1, 1'b1);
      feed(2, 32'b10, 32'b00);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      feed(2, 32'b11, 32'b01);

      // Illegal lengths then a legal reload
      do_load(4'b0000, 3'd5, 1'b1, 1'b0);
      feed(4, 32'b1011, 32'b0000);
      do_load(4'b1111, 3'd1, 1'b1, 1'b0);
      feed(3, 32'b111, 32'b000);
      do_load(4'b1011, 3'd4, 1'b1, 1'b1);
      feed(4, 32'b1011, 32'b0001);

      // Reload mid-pattern discards the partial history
      feed(3, 32'b101, 32'b000);
      do_load(4'b1011, 3'd4, 1'b1, 1'b1);
      feed(4, 32'b1011, 32'b0001);

      // 3-bit pattern 110; stored upper bit is ignored
      do_load(4'b1110, 3'd3, 1'b1, 1'b1);
      feed(6, 32'b110110, 32'b001001);

      // Reset mid-pattern
      do_load(4'b1011, 3'd4, 1'b1, 1'b1);
      feed(3, 32'b101, 32'b000);
      @(negedge CLK);
      #2 RST = 1'b0;
      #1 chk_all_zero("midreset");
      exp_cnt   = 8'd0;
      exp_armed = 1'b0;
      exp_err   = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      feed(2, 32'b11, 32'b00);

      // Saturation with pattern 11, then clear during a match
      do_load(4'b0011, 3'd2, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b0, (i != 0));
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      t = 0;
      while (q.size() > 0 && t < 10) begin
         @(posedge CLK);
         t++;
      end
      #2 chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
